// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared definitions for the FFT frame initiator: the
//                initiator state encoding, default bus window addresses and
//                the default frame length.
//  Contents    : fft_init_state_t      - initiator FSM state encoding
//                FFT_DEFAULT_BASE_ADDR - default write window base
//                FFT_DEFAULT_RD_OFFSET - default read window offset
//                N_POINT_FFT           - default samples per frame
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Initiator FSM states. The encoding is fixed so that the states can also
  // be used as plain 3-bit constants by modules that keep a logic vector.
  typedef enum logic [2:0] {
    FFT_ACCEPT = 3'd0,
    FFT_WR_REQ = 3'd1,
    FFT_WR_GAP = 3'd2,
    FFT_DELAY  = 3'd3,
    FFT_RD_REQ = 3'd4,
    FFT_OUT    = 3'd5
  } fft_init_state_t;

  localparam logic [31:0] FFT_DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] FFT_DEFAULT_RD_OFFSET = 32'h0000_0100;
  localparam int          N_POINT_FFT           = 16;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_bus_access.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bus_access
//  Description : Single outstanding request engine for the controller's CPU
//                register port. A start pulse raises either the read or the
//                write request on the next cycle; the request is held until
//                the target signals completion or the wait budget runs out.
//  Ports       : clkk            in  clock
//                reset           in  synchronous active-high reset
//                start           in  launch a request (next cycle)
//                start_write     in  1 = write request, 0 = read request
//                access_complete in  target completion strobe
//                req_read        out registered read request
//                req_write       out registered write request
//                done            out completion seen this cycle
//                timeout         out wait budget exhausted this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bus_access
  import fft_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clkk,
  input  logic reset,
  input  logic start,
  input  logic start_write,
  input  logic access_complete,
  output logic req_read,
  output logic req_write,
  output logic done,
  output logic timeout
);

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             active;
  logic [TMO_W-1:0] wait_cnt;

  assign active = req_read | req_write;

  // Completion is only meaningful while a request is outstanding; strobes
  // arriving at any other time are ignored here.
  assign done    = active & access_complete;

  // Completion takes priority over an expiring budget in the same cycle.
  assign timeout = active & ~access_complete & (wait_cnt == TMO_LAST);

  // wait_cnt equals the number of cycles the current request has already
  // been presented, so it reads 0 in the first request cycle.
  always_ff @(posedge clkk) begin
    if (reset) begin
      req_read  <= 1'b0;
      req_write <= 1'b0;
      wait_cnt  <= '0;
    end else if (start) begin
      req_write <= start_write;
      req_read  <= ~start_write;
      wait_cnt  <= '0;
    end else if (done || timeout) begin
      req_read  <= 1'b0;
      req_write <= 1'b0;
      wait_cnt  <= '0;
    end else if (active) begin
      wait_cnt  <= wait_cnt + 1'b1;
    end
  end

endmodule : fft_bus_access
`default_nettype wire

// File: rtl/fft_frame_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_initiator
//  Description : Bus initiator for the FFT controller's CPU register port.
//                Accepts one frame of N_POINT packed {imag,real} samples on
//                a valid/ready stream, writes them one word at a time into
//                the controller's write window, waits RESULT_DELAY cycles,
//                then reads N_POINT results from the read window and streams
//                them out with a last marker.
//  Ports       : clkk, reset            clock, synchronous active-high reset
//                s_valid/s_ready/s_data input sample stream
//                cpu_if_*               controller register port (initiator)
//                m_valid/m_ready/m_data/m_last  result stream
//                busy                   frame in progress
//                frame_done             one-cycle pulse after the last result
//                error                  sticky request timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_initiator
  import fft_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    N_POINT        = N_POINT_FFT,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(FFT_DEFAULT_BASE_ADDR),
  parameter logic [ADDR_WIDTH-1:0] RD_OFFSET      = ADDR_WIDTH'(FFT_DEFAULT_RD_OFFSET),
  parameter int                    RESULT_DELAY   = 64,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clkk,
  input  logic                  reset,
  // sample input stream
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  // controller register port
  output logic                  cpu_if_read,
  output logic                  cpu_if_write,
  output logic [ADDR_WIDTH-1:0] cpu_if_address,
  output logic [DATA_WIDTH-1:0] cpu_if_write_data,
  input  logic [DATA_WIDTH-1:0] cpu_if_read_data,
  input  logic                  cpu_if_access_complete,
  // result output stream
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  // status
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_ACCEPT = FFT_ACCEPT;
  localparam logic [2:0] ST_WR_REQ = FFT_WR_REQ;
  localparam logic [2:0] ST_WR_GAP = FFT_WR_GAP;
  localparam logic [2:0] ST_DELAY  = FFT_DELAY;
  localparam logic [2:0] ST_RD_REQ = FFT_RD_REQ;
  localparam logic [2:0] ST_OUT    = FFT_OUT;

  // idx must be able to hold N_POINT itself (end-of-write-phase marker).
  localparam int               IDX_W    = $clog2(N_POINT) + 1;
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_POINT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_POINT - 1);

  localparam int               DLY_W    = $clog2(RESULT_DELAY + 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RESULT_DELAY - 1);

  // --------------------------------------------------------------------------
  // State and control
  // --------------------------------------------------------------------------
  logic [2:0]            state;
  logic [2:0]            state_n;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_n;
  logic [DLY_W-1:0]      dly_cnt;

  logic                  acc_start;
  logic                  acc_start_write;
  logic                  acc_done;
  logic                  acc_timeout;

  logic                  load_wr;     // latch sample and write address
  logic                  load_rd;     // load read address for idx_n
  logic                  capture;     // take read data into the result stage
  logic                  finish;      // final result handed over
  logic                  set_error;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Address arithmetic deliberately wraps at ADDR_WIDTH bits.
  assign wr_addr = BASE_ADDR + (ADDR_WIDTH'(idx) << 2);
  assign rd_addr = BASE_ADDR + RD_OFFSET + (ADDR_WIDTH'(idx_n) << 2);

  // --------------------------------------------------------------------------
  // Shared request engine for both the write and the read phase
  // --------------------------------------------------------------------------
  fft_bus_access #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_access (
    .clkk            (clkk),
    .reset           (reset),
    .start           (acc_start),
    .start_write     (acc_start_write),
    .access_complete (cpu_if_access_complete),
    .req_read        (cpu_if_read),
    .req_write       (cpu_if_write),
    .done            (acc_done),
    .timeout         (acc_timeout)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n         = state;
    idx_n           = idx;
    acc_start       = 1'b0;
    acc_start_write = 1'b0;
    load_wr         = 1'b0;
    load_rd         = 1'b0;
    capture         = 1'b0;
    finish          = 1'b0;
    set_error       = 1'b0;

    case (state)
      ST_ACCEPT: begin
        if (s_valid && s_ready) begin
          load_wr         = 1'b1;
          acc_start       = 1'b1;
          acc_start_write = 1'b1;
          state_n         = ST_WR_REQ;
        end
      end

      ST_WR_REQ: begin
        if (acc_done) begin
          idx_n   = idx + 1'b1;
          state_n = ST_WR_GAP;
        end else if (acc_timeout) begin
          // The remainder of the frame is abandoned.
          set_error = 1'b1;
          idx_n     = '0;
          state_n   = ST_ACCEPT;
        end
      end

      ST_WR_GAP: begin
        if (idx == IDX_FULL) begin
          idx_n   = '0;
          state_n = ST_DELAY;
        end else begin
          state_n = ST_ACCEPT;
        end
      end

      ST_DELAY: begin
        // The read request is launched on the last delay cycle so that it
        // becomes visible exactly RESULT_DELAY cycles after entering DELAY.
        if (dly_cnt == DLY_LAST) begin
          load_rd   = 1'b1;
          acc_start = 1'b1;
          state_n   = ST_RD_REQ;
        end
      end

      ST_RD_REQ: begin
        if (acc_done) begin
          capture = 1'b1;
          state_n = ST_OUT;
        end else if (acc_timeout) begin
          set_error = 1'b1;
          idx_n     = '0;
          state_n   = ST_ACCEPT;
        end
      end

      ST_OUT: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            idx_n   = '0;
            finish  = 1'b1;
            state_n = ST_ACCEPT;
          end else begin
            idx_n     = idx + 1'b1;
            load_rd   = 1'b1;
            acc_start = 1'b1;
            state_n   = ST_RD_REQ;
          end
        end
      end

      default: begin
        idx_n   = '0;
        state_n = ST_ACCEPT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Result delay counter: zero on entry to DELAY, counts while there
  // --------------------------------------------------------------------------
  always_ff @(posedge clkk) begin
    if (reset || (state != ST_DELAY)) begin
      dly_cnt <= '0;
    end else begin
      dly_cnt <= dly_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State, data path and registered status outputs
  // --------------------------------------------------------------------------
  // s_ready and busy are registered from the next-state values so that they
  // line up with the state they describe without a combinational path.
  always_ff @(posedge clkk) begin
    if (reset) begin
      state             <= ST_ACCEPT;
      idx               <= '0;
      s_ready           <= 1'b1;
      cpu_if_address    <= '0;
      cpu_if_write_data <= '0;
      m_valid           <= 1'b0;
      m_data            <= '0;
      m_last            <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      error             <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      s_ready    <= (state_n == ST_ACCEPT);
      busy       <= (state_n != ST_ACCEPT) || (idx_n != '0);
      frame_done <= finish;

      if (set_error) begin
        error <= 1'b1;
      end

      if (load_wr) begin
        cpu_if_address    <= wr_addr;
        cpu_if_write_data <= s_data;
      end else if (load_rd) begin
        cpu_if_address    <= rd_addr;
      end

      // m_data/m_last stay put while the consumer stalls.
      if (capture) begin
        m_valid <= 1'b1;
        m_data  <= cpu_if_read_data;
        m_last  <= (idx == IDX_LAST);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule : fft_frame_initiator
`default_nettype wire
